// File: rtl/marker_pkg.sv
// Shared types and widths for the marker scan controller and its run tracker.
package marker_pkg;

  localparam int DEF_SCREEN_WIDTH  = 1024;
  localparam int DEF_SCREEN_HEIGHT = 768;
  localparam int DEF_MAX_WIDTH     = 150;

  localparam int X_W    = $clog2(DEF_SCREEN_WIDTH) + 1;
  localparam int Y_W    = $clog2(DEF_SCREEN_HEIGHT) + 1;
  localparam int WID_W  = $clog2(DEF_MAX_WIDTH) + 1;
  localparam int PROB_W = 11;

  localparam logic [PROB_W-1:0] PROB_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ROW_COMMIT,
    FRAME_COMMIT
  } scan_state_t;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [WID_W-1:0]  width;
    logic [PROB_W-1:0] prob;
  } cand_t;

  // Unsigned distance without wrap-around.
  function automatic logic [X_W-1:0] abs_diff(input logic [X_W-1:0] a,
                                              input logic [X_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/marker_run_tracker.sv
// Tracks one run of vertically consecutive, x-aligned row candidates and
// reports it as a frame candidate when it is closed.
module marker_run_tracker
  import marker_pkg::*;
#(
  parameter int SCREEN_HEIGHT = 768,
  parameter int MIN_ROWS      = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           open_cmd,
  input  logic           extend_cmd,
  input  logic           close_cmd,
  input  cand_t          row_cand,
  output logic           run_open,
  output logic [X_W-1:0] run_last_x,
  output cand_t          closed_cand,
  output logic           closed_accept
);

  logic [Y_W-1:0]    run_start;
  logic [Y_W-1:0]    run_end;
  logic [Y_W-1:0]    run_len;
  logic [X_W-1:0]    best_x;
  logic [WID_W-1:0]  best_w;
  logic [PROB_W-1:0] best_prob;
  logic [Y_W:0]      mid_sum;

  assign mid_sum = {1'b0, run_start} + {1'b0, run_end};

  always_comb begin
    closed_cand       = '0;
    closed_cand.x     = best_x;
    closed_cand.y     = Y_W'(mid_sum >> 1);
    closed_cand.width = best_w;
    closed_cand.prob  = best_prob;
    closed_accept     = close_cmd && run_open && (run_len >= Y_W'(MIN_ROWS));
  end

  // open wins over close so a close-then-reopen happens in one cycle
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_open   <= 1'b0;
      run_start  <= '0;
      run_end    <= '0;
      run_len    <= '0;
      run_last_x <= '0;
      best_x     <= '0;
      best_w     <= '0;
      best_prob  <= PROB_MAX;
    end else if (open_cmd) begin
      run_open   <= 1'b1;
      run_start  <= row_cand.y;
      run_end    <= row_cand.y;
      run_len    <= Y_W'(1);
      run_last_x <= row_cand.x;
      best_x     <= row_cand.x;
      best_w     <= row_cand.width;
      best_prob  <= row_cand.prob;
    end else if (extend_cmd) begin
      run_end    <= row_cand.y;
      run_last_x <= row_cand.x;
      if (run_len < Y_W'(SCREEN_HEIGHT)) run_len <= run_len + Y_W'(1);
      if (row_cand.prob < best_prob) begin
        best_x    <= row_cand.x;
        best_w    <= row_cand.width;
        best_prob <= row_cand.prob;
      end
    end else if (close_cmd) begin
      run_open  <= 1'b0;
      run_len   <= '0;
      best_prob <= PROB_MAX;
    end
  end

endmodule

// File: rtl/marker_scan_ctrl.sv
// Sequences the per-row stripe detector over a frame and reports one marker
// per frame. Optional MARKER_HOLD_EN holds the last marker over up to 3 empty frames.
module marker_scan_ctrl
  import marker_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int MAX_WIDTH     = DEF_MAX_WIDTH,
  parameter int PROB_THRES    = 200,
  parameter int X_TOL         = 8,
  parameter int MIN_ROWS      = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [$clog2(SCREEN_WIDTH):0]    hcount_in,
  input  logic [$clog2(SCREEN_HEIGHT):0]   vcount_in,
  output logic                             det_rst_out,
  input  logic                             det_done_in,
  input  logic [$clog2(SCREEN_WIDTH):0]    det_coord_in,
  input  logic [$clog2(MAX_WIDTH):0]       det_width_in,
  input  logic [10:0]                      det_prob_in,
  output logic [$clog2(SCREEN_WIDTH):0]    marker_x_out,
  output logic [$clog2(SCREEN_HEIGHT):0]   marker_y_out,
  output logic [$clog2(MAX_WIDTH):0]       marker_width_out,
  output logic                             marker_found_out,
  output logic                             marker_valid_out
);

  localparam int VW = $clog2(SCREEN_HEIGHT) + 1;

  scan_state_t       state_q, state_d;
  logic [VW-1:0]     prev_vcount;
  logic              prev_done;
  logic              new_row, new_frame, done_rise;
  logic [Y_W-1:0]    commit_y;

  logic [X_W-1:0]    row_x;
  logic [WID_W-1:0]  row_w;
  logic [PROB_W-1:0] row_prob;
  logic              row_has;
  logic              cand_take;

  cand_t             frame_best, frame_next, row_cand, closed_cand;
  logic              frame_has, frame_has_next, take_run;

  logic              is_row, is_frame, row_ok, near;
  logic              open_cmd, extend_cmd, close_cmd;
  logic              run_open, closed_accept;
  logic [X_W-1:0]    run_last_x;

  // Column position is not needed for sequencing; kept on the port for the detector bus.
  logic unused_hcount;
  assign unused_hcount = ^hcount_in;

  assign new_row   = (vcount_in != prev_vcount);
  assign new_frame = (vcount_in < prev_vcount);
  assign done_rise = det_done_in & ~prev_done;
  assign cand_take = (state_q == SCAN) && done_rise &&
                     (det_prob_in < PROB_W'(PROB_THRES)) && (det_prob_in < row_prob);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (new_frame) state_d = SCAN;
      SCAN: begin
        if (new_frame)    state_d = FRAME_COMMIT;
        else if (new_row) state_d = ROW_COMMIT;
      end
      ROW_COMMIT:   state_d = SCAN;
      FRAME_COMMIT: state_d = SCAN;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      prev_vcount <= '0;
      prev_done   <= 1'b0;
      det_rst_out <= 1'b1;
      commit_y    <= '0;
    end else begin
      state_q     <= state_d;
      prev_vcount <= vcount_in;
      prev_done   <= det_done_in;
      det_rst_out <= new_row | (state_d == IDLE) | (vcount_in >= VW'(SCREEN_HEIGHT));
      // prev_vcount has already moved on by the commit cycle, so keep the closing row
      if (new_row) commit_y <= prev_vcount;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row_x    <= '0;
      row_w    <= '0;
      row_prob <= PROB_MAX;
      row_has  <= 1'b0;
    end else if (state_q != SCAN) begin
      row_x    <= '0;
      row_w    <= '0;
      row_prob <= PROB_MAX;
      row_has  <= 1'b0;
    end else if (cand_take) begin
      row_x    <= det_coord_in;
      row_w    <= det_width_in;
      row_prob <= det_prob_in;
      row_has  <= 1'b1;
    end
  end

  always_comb begin
    is_row         = (state_q == ROW_COMMIT);
    is_frame       = (state_q == FRAME_COMMIT);
    row_ok         = row_has && (commit_y < Y_W'(SCREEN_HEIGHT));
    near           = abs_diff(row_x, run_last_x) <= X_W'(X_TOL);
    extend_cmd     = is_row && row_ok && run_open && near;
    open_cmd       = is_row && row_ok && !(run_open && near);
    close_cmd      = is_frame || (is_row && !extend_cmd);
    row_cand       = '0;
    row_cand.x     = row_x;
    row_cand.y     = commit_y;
    row_cand.width = row_w;
    row_cand.prob  = row_prob;
    take_run       = closed_accept && (closed_cand.prob < frame_best.prob);
    frame_next     = take_run ? closed_cand : frame_best;
    frame_has_next = frame_has | take_run;
  end

  marker_run_tracker #(
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .MIN_ROWS     (MIN_ROWS)
  ) u_run (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .open_cmd     (open_cmd),
    .extend_cmd   (extend_cmd),
    .close_cmd    (close_cmd),
    .row_cand     (row_cand),
    .run_open     (run_open),
    .run_last_x   (run_last_x),
    .closed_cand  (closed_cand),
    .closed_accept(closed_accept)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_best      <= '0;
      frame_best.prob <= PROB_MAX;
      frame_has       <= 1'b0;
    end else if (is_row) begin
      frame_best <= frame_next;
      frame_has  <= frame_has_next;
    end else if (is_frame) begin
      frame_best      <= '0;
      frame_best.prob <= PROB_MAX;
      frame_has       <= 1'b0;
    end
  end

`ifdef MARKER_HOLD_EN
  logic [1:0] hold_cnt;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      marker_x_out     <= '0;
      marker_y_out     <= '0;
      marker_width_out <= '0;
      marker_found_out <= 1'b0;
      marker_valid_out <= 1'b0;
`ifdef MARKER_HOLD_EN
      hold_cnt         <= '0;
`endif
    end else begin
      marker_valid_out <= is_frame;
      if (is_frame) begin
        if (frame_has_next) begin
          marker_x_out     <= frame_next.x;
          marker_y_out     <= frame_next.y;
          marker_width_out <= frame_next.width;
          marker_found_out <= 1'b1;
`ifdef MARKER_HOLD_EN
          hold_cnt         <= '0;
`endif
        end else begin
`ifdef MARKER_HOLD_EN
          if (marker_found_out && (hold_cnt != 2'd3)) begin
            hold_cnt <= hold_cnt + 2'd1;
          end else begin
            marker_x_out     <= '0;
            marker_y_out     <= '0;
            marker_width_out <= '0;
            marker_found_out <= 1'b0;
          end
`else
          marker_x_out     <= '0;
          marker_y_out     <= '0;
          marker_width_out <= '0;
          marker_found_out <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
